srnorm: RTL
===========

# srnorm

Pipelined normalize-and-pack stage that sits directly downstream of the single-precision mantissa adder in the FFT butterfly datapath. It accepts an unnormalized sum (sign, widened exponent, 48-bit mantissa) and emits a packed IEEE-754 single-precision word. It is a 2-stage valid/ready pipeline with throughput of one result per cycle. It applies the datapath conventions: flush-to-zero on underflow, all-ones NaN on overflow.

## Interface
- No parameters; widths are fixed for single precision.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input word present
- in_ready  output  1  stage accepts input this cycle
- in_sign  input  1  sign of sum
- in_exp  input  10  biased exponent, two's complement, range -512..511
- in_mant  input  48  magnitude; value = in_mant / 2^46 × 2^(in_exp−127); normalized leading one at bit 46, adder carry at bit 47
- out_valid  output  1  z/out_flags valid
- out_ready  input  1  downstream accepts
- z  output  32  packed SP result
- out_flags  output  2  {ovf, unf}, qualified by out_valid

## Operation
- Stage 1 (S1) registers the sign and exponent. It computes p, the position of the leading one in in_mant (0..47), using a priority encoder. It registers the normalized exponent e_n = in_exp + p − 46, the left-shift amount 47 − p, and a zero flag (in_mant == 0).
- Stage 2 (S2) shifts the mantissa so its leading one lands at bit 47. The fraction is bits 46:24, guard is bit 23, and sticky is the OR of bits 22:0. S2 then rounds (see Configuration), range-checks, and packs.
- Rounding carry-out is handled as follows: if the rounded fraction overflows 23 bits, the fraction becomes 0 and e_n is incremented by 1. The range check is done after this increment.
- Result selection, in priority order:
  - zero flag set: z = 32'h00000000, flags 0. The sign is dropped.
  - e_n ≥ 255: z = 32'hFFFFFFFF, ovf = 1.
  - e_n ≤ 0: z = 32'h00000000, unf = 1. No subnormals are ever produced.
  - otherwise: z = {sign, e_n[7:0], fraction}.
- Handshake:
  - adv2 = !s2_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1 && !rst
  - A transfer occurs when valid && ready at a clock edge.
  - Input fields must be held stable while in_valid && !in_ready.
- Ordering is strictly FIFO and no result is dropped or duplicated. While out_valid && !out_ready, z and out_flags must not change.
- Simultaneous accept and drain in the same cycle is legal and sustains full throughput.

## Timing
- Latency is 2 cycles: an input accepted at edge N appears with out_valid high after edge N+1, and is consumed at edge N+2 or later.
- Throughput is 1 per cycle while out_ready stays high.
- Pipeline capacity is 2 words. With out_ready low, the stage accepts 2 words, then in_ready drops combinationally.
- in_ready has a combinational path from out_ready. There is no path from in_valid to in_ready.
- Reset values, applied asynchronously on rst high:
  - out_valid = 0, z = 0, out_flags = 0
  - S1/S2 valid flags cleared
  - in_ready = 0 while rst is high, and 1 on the first cycle after release
- Reset mid-operation discards all in-flight words. No output is produced for them.

## Configuration
- SRNORM_ROUND_EN defined: round-to-nearest-even.
  - Increment the fraction when guard && (sticky || fraction[0]).
  - The rounding carry can raise e_n to 255, which yields NaN with ovf set.
- SRNORM_ROUND_EN undefined: truncation. Guard and sticky are ignored, which matches the existing adder's chopping behaviour.
- Latency and handshake are identical in both builds.

## Test plan
- 1.0+1.0: in_exp=127, in_mant=48'h800000000000, sign 0 -> z=32'h40000000, flags 0, out_valid exactly 2 cycles after accept.
- Tie rounding: in_exp=127, in_mant=48'h400000C00000.
  - With SRNORM_ROUND_EN: z=32'h3F800002.
  - Without it: z=32'h3F800001.
- Range limits:
  - in_exp=254, in_mant=48'h800000000000 -> z=32'hFFFFFFFF, ovf=1.
  - in_exp=1, in_mant=48'h200000000000 -> z=0, unf=1.
  - in_mant=0, sign 1 -> z=0, flags 0.
- Backpressure: hold out_ready=0 and drive in_valid=1 with 3 distinct words.
  - in_ready must drop after 2 accepts, and z must stay stable.
  - Release out_ready: the 3 results come out in order on consecutive cycles, and the third word is accepted on release.
- Streaming: 100 random words with out_ready=1 -> one result per cycle, in order.
  - Results must match a reference model (truncation or RNE per build, FTZ, NaN on overflow).
- Reset mid-stream: assert rst with 2 words in flight.
  - out_valid goes to 0 immediately, with no later spurious output.
  - in_ready returns to 1 one cycle after release.

Source files
------------

// File: rtl/srnorm.sv
// rtl/srnorm.sv - two-stage normalize-and-pack from widened adder sum to IEEE-754 single
//
// Purpose: takes the unnormalized mantissa-adder sum (sign, 10-bit two's complement
// biased exponent, 48-bit magnitude with nominal leading one at bit 46) and emits a
// packed single-precision word. Underflow flushes to zero, overflow yields all-ones.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    input handshake
//   in_sign, in_exp      sign and biased exponent of the sum
//   in_mant              48-bit magnitude, value = in_mant / 2^46 * 2^(in_exp-127)
//   out_valid/out_ready  output handshake
//   z                    packed single-precision result
//   out_flags            {ovf, unf}, qualified by out_valid
//
// Build option: SRNORM_ROUND_EN selects round-to-nearest-even; otherwise truncation.

module srnorm (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sign,
   input  logic [9:0]  in_exp,
   input  logic [47:0] in_mant,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] z,
   output logic [1:0]  out_flags
);

   logic               adv1, adv2;
   logic               s1_valid, s1_sign, s1_zero;
   logic signed [10:0] s1_en;
   logic [5:0]         s1_shamt;
   logic [47:0]        s1_mant;

   logic [5:0]         lead_pos;
   logic signed [10:0] en_calc;

   logic [47:0]        sh;
   logic [22:0]        frac;
   logic               inc;
   logic [23:0]        frac_r;
   logic signed [10:0] e_r;
   logic [31:0]        z_next;
   logic [1:0]         flags_next;

   assign adv2     = !out_valid || out_ready;
   assign adv1     = !s1_valid || adv2;
   assign in_ready = adv1 && !rst;

   // Leading-one position; higher bits override lower ones.
   always_comb begin
      lead_pos = 6'd0;
      for (int i = 0; i < 48; i++) begin
         if (in_mant[i]) lead_pos = 6'(i);
      end
   end

   // 11 bits hold in_exp + p - 46 (range -558..512) plus the rounding increment.
   assign en_calc = $signed({in_exp[9], in_exp}) + $signed({5'd0, lead_pos}) - 11'sd46;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_zero  <= 1'b0;
         s1_en    <= '0;
         s1_shamt <= '0;
         s1_mant  <= '0;
      end else if (adv1) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sign  <= in_sign;
            s1_zero  <= (in_mant == 48'd0);
            s1_en    <= en_calc;
            s1_shamt <= 6'd47 - lead_pos;
            s1_mant  <= in_mant;
         end
      end
   end

   // Leading one moved to bit 47; fraction is bits 46:24.
   assign sh   = s1_mant << s1_shamt;
   assign frac = 23'(sh >> 24);

`ifdef SRNORM_ROUND_EN
   logic guard, sticky;
   assign guard  = sh[23];
   assign sticky = |sh[22:0];
   assign inc    = guard && (sticky || frac[0]);
`else
   assign inc    = 1'b0;
`endif

   // A carry out of the 23-bit fraction wraps it to zero and bumps the exponent;
   // the range check below sees the bumped exponent.
   assign frac_r = {1'b0, frac} + {23'd0, inc};
   assign e_r    = s1_en + (frac_r[23] ? 11'sd1 : 11'sd0);

   always_comb begin
      z_next     = 32'h0000_0000;
      flags_next = 2'b00;
      if (s1_zero) begin
         z_next     = 32'h0000_0000;
      end else if (e_r >= 11'sd255) begin
         z_next     = 32'hFFFF_FFFF;
         flags_next = 2'b10;
      end else if (e_r <= 11'sd0) begin
         z_next     = 32'h0000_0000;
         flags_next = 2'b01;
      end else begin
         z_next     = {s1_sign, e_r[7:0], frac_r[22:0]};
      end
   end

   // Output registers only load when advancing, so they hold while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         z         <= '0;
         out_flags <= '0;
      end else if (adv2) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            z         <= z_next;
            out_flags <= flags_next;
         end
      end
   end

endmodule
